// File: rtl/y_shifter_pkg.sv
// Shared encodings for the Y operand shifter: shift modes and controller states.
package y_shifter_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/y_shifter_step.sv
// One single-bit shift step of Y in the given mode, producing the next Y and
// the bit shifted out.
module y_shifter_step
    import y_shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_next,
    output logic             carry
);

    always_comb begin
        y_next = y;
        carry  = 1'b0;
        case (mode)
            SH_LSL: begin
                y_next = {y[WIDTH-2:0], 1'b0};
                carry  = y[WIDTH-1];
            end
            SH_LSR: begin
                y_next = {1'b0, y[WIDTH-1:1]};
                carry  = y[0];
            end
            SH_ASR: begin
                y_next = {y[WIDTH-1], y[WIDTH-1:1]};
                carry  = y[0];
            end
            SH_ROL: begin
                y_next = {y[WIDTH-2:0], y[WIDTH-1]};
                carry  = y[WIDTH-1];
            end
            default: begin
                y_next = y;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/y_shifter.sv
// Y operand register for the ALU: loads from the bus and shifts one bit per
// clock for a programmed number of steps, signalling completion with shift_done.
module y_shifter
    import y_shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bus,
    input  logic             Y_load,
    input  logic             shift_start,
    input  logic [1:0]       shift_mode,
    input  logic [AMT_W-1:0] shift_amount,
    output logic [WIDTH-1:0] y_shifted,
    output logic             shift_busy,
    output logic             shift_done,
    output logic             shift_carry
);

    state_t           state;
    logic [WIDTH-1:0] y;
    logic [AMT_W-1:0] count;
    logic [1:0]       mode;
    logic             carry;
    logic [WIDTH-1:0] step_y;
    logic             step_carry;

    y_shifter_step #(.WIDTH(WIDTH)) u_step (
        .mode   (mode),
        .y      (y),
        .y_next (step_y),
        .carry  (step_carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            y     <= '0;
            count <= '0;
            mode  <= SH_LSL;
            carry <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (Y_load) begin
                        y     <= bus;
                        state <= ST_IDLE;
                    end else if (shift_start) begin
                        if (shift_amount == '0) begin
                            carry <= 1'b0;
                            state <= ST_DONE;
                        end else begin
                            mode  <= shift_mode;
                            count <= shift_amount;
                            state <= ST_SHIFT;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    // A load aborts the shift; carry keeps the last performed step.
                    if (Y_load) begin
                        y     <= bus;
                        state <= ST_IDLE;
                    end else begin
                        y     <= step_y;
                        carry <= step_carry;
                        count <= count - AMT_W'(1);
                        if (count == AMT_W'(1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign y_shifted   = y;
    assign shift_carry = carry;
    assign shift_busy  = (state == ST_SHIFT);
    assign shift_done  = (state == ST_DONE);

endmodule

// File: tb/tb_y_shifter.sv
// Bench for y_shifter: directed vector table, hand-written corner sequences
// and random traffic compared against an arithmetic reference model.
module tb_y_shifter;
    import y_shifter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] bus = '0;
    logic        Y_load = 1'b0;
    logic        shift_start = 1'b0;
    logic [1:0]  shift_mode = '0;
    logic [3:0]  shift_amount = '0;
    logic [15:0] y_shifted;
    logic        shift_busy;
    logic        shift_done;
    logic        shift_carry;

    int checks = 0;
    int failures = 0;

    // Reference model: Y value, carry, steps still to perform, done pulse.
    int          m_y;
    logic        m_c;
    int          m_rem;
    logic        m_done;
    logic [1:0]  m_mode;

    typedef struct {
        logic        ld;
        logic [15:0] b;
        logic        st;
        logic [1:0]  md;
        logic [3:0]  am;
        logic [15:0] y;
        logic        busy;
        logic        done;
        logic        c;
    } vec_t;

    vec_t tbl[$];

    y_shifter #(.WIDTH(16), .AMT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .Y_load       (Y_load),
        .shift_start  (shift_start),
        .shift_mode   (shift_mode),
        .shift_amount (shift_amount),
        .y_shifted    (y_shifted),
        .shift_busy   (shift_busy),
        .shift_done   (shift_done),
        .shift_carry  (shift_carry)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ld, input logic [15:0] b, input logic st,
                                input logic [1:0] md, input logic [3:0] am,
                                input logic [15:0] y, input logic busy,
                                input logic done, input logic c);
        vec_t v;
        v.ld = ld; v.b = b; v.st = st; v.md = md; v.am = am;
        v.y = y; v.busy = busy; v.done = done; v.c = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_y = 0; m_c = 1'b0; m_rem = 0; m_done = 1'b0; m_mode = SH_LSL;
    endtask

    task automatic model_update(input logic ld, input logic [15:0] b, input logic st,
                                input logic [1:0] md, input logic [3:0] am);
        int v;
        v = m_y;
        if (m_rem > 0) begin
            if (ld) begin
                m_y = int'(b); m_rem = 0; m_done = 1'b0;
            end else begin
                case (m_mode)
                    SH_LSL: begin m_c = ((v / 32768) % 2) == 1; v = (v * 2) % 65536; end
                    SH_LSR: begin m_c = (v % 2) == 1; v = v / 2; end
                    SH_ASR: begin m_c = (v % 2) == 1; v = v / 2 + ((v >= 32768) ? 32768 : 0); end
                    default: begin m_c = ((v / 32768) % 2) == 1; v = (v * 2) % 65536 + v / 32768; end
                endcase
                m_y = v;
                m_rem--;
                m_done = (m_rem == 0);
            end
        end else begin
            m_done = 1'b0;
            if (ld) begin
                m_y = int'(b);
            end else if (st) begin
                if (am == 4'd0) begin
                    m_c = 1'b0; m_done = 1'b1;
                end else begin
                    m_mode = md; m_rem = int'(am);
                end
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model, sample 1 time unit later.
    task automatic apply(input logic ld, input logic [15:0] b, input logic st,
                         input logic [1:0] md, input logic [3:0] am);
        Y_load = ld; bus = b; shift_start = st; shift_mode = md; shift_amount = am;
        @(posedge clk);
        model_update(ld, b, st, md, am);
        #1;
        Y_load = 1'b0; shift_start = 1'b0;
        bus = 16'($urandom); shift_mode = 2'($urandom); shift_amount = 4'($urandom);
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, " y"}, 32'(y_shifted), 32'(m_y[15:0]));
        chk({tag, " busy"}, 32'(shift_busy), 32'(m_rem > 0));
        chk({tag, " done"}, 32'(shift_done), 32'(m_done));
        chk({tag, " carry"}, 32'(shift_carry), 32'(m_c));
    endtask

    initial begin
        int n;
        model_reset();

        tbl.push_back(mk(1, 16'h8001, 0, SH_LSL, 0, 16'h8001, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 1, SH_LSL, 1, 16'h8001, 1, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 0, SH_LSL, 0, 16'h0002, 0, 1, 1));
        tbl.push_back(mk(0, 16'h0000, 0, SH_LSL, 0, 16'h0002, 0, 0, 1));
        tbl.push_back(mk(1, 16'h1234, 0, SH_LSL, 0, 16'h1234, 0, 0, 1));
        tbl.push_back(mk(0, 16'h0000, 1, SH_ROL, 4, 16'h1234, 1, 0, 1));
        tbl.push_back(mk(0, 16'h0000, 0, SH_LSL, 0, 16'h2468, 1, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 0, SH_LSL, 0, 16'h48D0, 1, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 0, SH_LSL, 0, 16'h91A0, 1, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 0, SH_LSL, 0, 16'h2341, 0, 1, 1));
        tbl.push_back(mk(0, 16'h0000, 1, SH_LSL, 0, 16'h2341, 0, 1, 0));
        tbl.push_back(mk(0, 16'h0000, 0, SH_LSL, 0, 16'h2341, 0, 0, 0));
        tbl.push_back(mk(1, 16'hF0F0, 0, SH_LSL, 0, 16'hF0F0, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 1, SH_LSR, 8, 16'hF0F0, 1, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 0, SH_LSL, 0, 16'h7878, 1, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 0, SH_LSL, 0, 16'h3C3C, 1, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 0, SH_LSL, 0, 16'h1E1E, 1, 0, 0));
        tbl.push_back(mk(1, 16'hAAAA, 0, SH_LSL, 0, 16'hAAAA, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 0, SH_LSL, 0, 16'hAAAA, 0, 0, 0));
        tbl.push_back(mk(1, 16'h0F00, 1, SH_LSL, 2, 16'h0F00, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 0, SH_LSL, 0, 16'h0F00, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 1, SH_LSL, 1, 16'h0F00, 1, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 0, SH_LSL, 0, 16'h1E00, 0, 1, 0));
        tbl.push_back(mk(0, 16'h0000, 1, SH_LSR, 2, 16'h1E00, 1, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 0, SH_LSL, 0, 16'h0F00, 1, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 0, SH_LSL, 0, 16'h0780, 0, 1, 0));
        tbl.push_back(mk(0, 16'h0000, 0, SH_LSL, 0, 16'h0780, 0, 0, 0));
        tbl.push_back(mk(1, 16'h0003, 0, SH_LSL, 0, 16'h0003, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 1, SH_LSR, 4, 16'h0003, 1, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 0, SH_LSL, 0, 16'h0001, 1, 0, 1));
        tbl.push_back(mk(1, 16'h1111, 0, SH_LSL, 0, 16'h1111, 0, 0, 1));
        tbl.push_back(mk(0, 16'h0000, 0, SH_LSL, 0, 16'h1111, 0, 0, 1));

        repeat (2) @(posedge clk);
        #1;
        chk("reset y", 32'(y_shifted), 32'h0);
        chk("reset busy", 32'(shift_busy), 32'h0);
        chk("reset done", 32'(shift_done), 32'h0);
        chk("reset carry", 32'(shift_carry), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].ld, tbl[i].b, tbl[i].st, tbl[i].md, tbl[i].am);
            chk($sformatf("row%0d y", i), 32'(y_shifted), 32'(tbl[i].y));
            chk($sformatf("row%0d busy", i), 32'(shift_busy), 32'(tbl[i].busy));
            chk($sformatf("row%0d done", i), 32'(shift_done), 32'(tbl[i].done));
            chk($sformatf("row%0d carry", i), 32'(shift_carry), 32'(tbl[i].c));
        end

        // ASR of 16'h8000 by 15: busy for 15 sampled cycles, then sign-filled.
        apply(1, 16'h8000, 0, SH_LSL, 0);
        apply(0, 16'h0000, 1, SH_ASR, 15);
        n = 0;
        while (shift_busy && n < 40) begin
            n++;
            apply(0, 16'h0000, 0, SH_LSL, 0);
        end
        chk("asr busy cycles", 32'(n), 32'd15);
        chk("asr done", 32'(shift_done), 32'h1);
        chk("asr y", 32'(y_shifted), 32'hFFFF);
        chk("asr carry", 32'(shift_carry), 32'h0);

        // Asynchronous reset in the middle of a shift, away from any clock edge.
        apply(1, 16'h5555, 0, SH_LSL, 0);
        apply(0, 16'h0000, 1, SH_LSL, 10);
        apply(0, 16'h0000, 0, SH_LSL, 0);
        apply(0, 16'h0000, 0, SH_LSL, 0);
        cmp_model("pre-reset");
        reset = 1'b1;
        #2;
        chk("async rst y", 32'(y_shifted), 32'h0);
        chk("async rst busy", 32'(shift_busy), 32'h0);
        chk("async rst done", 32'(shift_done), 32'h0);
        chk("async rst carry", 32'(shift_carry), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        apply(1, 16'h0003, 0, SH_LSL, 0);
        apply(0, 16'h0000, 1, SH_LSR, 2);
        apply(0, 16'h0000, 0, SH_LSL, 0);
        apply(0, 16'h0000, 0, SH_LSL, 0);
        chk("post-rst y", 32'(y_shifted), 32'h0000);
        chk("post-rst done", 32'(shift_done), 32'h1);
        chk("post-rst carry", 32'(shift_carry), 32'h1);
        cmp_model("post-rst");

        for (int i = 0; i < 400; i++) begin
            logic       ld, st;
            logic [1:0] md;
            logic [3:0] am;
            ld = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 2) == 0);
            md = 2'($urandom);
            am = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            apply(ld, 16'($urandom), st, md, am);
            cmp_model($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/y_shifter.md
# y_shifter

Sequential Y operand register and shifter for the datapath. It loads a 16-bit operand from the internal bus and shifts it one bit per clock by a programmed amount. It drives the ALU's second operand (`y_shifted`) continuously, so the ALU combines `bus` with the current Y value on any cycle. The control sequencer starts a shift and waits for `shift_done` before issuing the ALU operation.

## Interface
Parameters:
- `WIDTH`, 16: data width of Y, `bus` and `y_shifted`.
- `AMT_W`, 4: width of `shift_amount`; maximum shift is 2^AMT_W − 1.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `bus` in WIDTH: internal data bus, the load source for Y.
- `Y_load` in 1: load Y from `bus`.
- `shift_start` in 1: begin a shift, using the `shift_mode` and `shift_amount` sampled in the same cycle.
- `shift_mode` in 2: 00 LSL, 01 LSR, 10 ASR, 11 ROL.
- `shift_amount` in AMT_W: number of single-bit shifts to perform.
- `y_shifted` out WIDTH: current Y register value, feeding the ALU.
- `shift_busy` out 1: high while shifting (SHIFT state).
- `shift_done` out 1: one-cycle pulse when a shift completes.
- `shift_carry` out 1: last bit shifted out of Y.

## Operation
- States: IDLE, SHIFT, DONE.
- Reset (asynchronous) clears Y, the counter, the latched mode and `shift_carry` to 0 and forces IDLE. After reset, `y_shifted` = 0, `shift_busy` = 0, `shift_done` = 0.

IDLE or DONE:
- `Y_load` loads Y ← `bus` and moves to IDLE.
- `Y_load` takes priority over `shift_start` in the same cycle; the start is dropped.
- `shift_start` with amount 0 → DONE. Y is unchanged and `shift_carry` is cleared.
- `shift_start` with amount N > 0 → SHIFT. Mode is latched and the counter is set to N.
- With neither `Y_load` nor `shift_start`, DONE returns to IDLE.

SHIFT:
- Each cycle applies one step of the latched mode and decrements the counter.
- The step with counter = 1 moves to DONE.
- `shift_start` is ignored.
- `Y_load` aborts the shift: Y ← `bus`, go to IDLE, no `shift_done`. `shift_carry` keeps the value from the last step performed.

Shift steps, each updating `shift_carry`:
- LSL: Y ← {Y[W−2:0], 0}, carry ← Y[W−1].
- LSR: Y ← {0, Y[W−1:1]}, carry ← Y[0].
- ASR: Y ← {Y[W−1], Y[W−1:1]}, carry ← Y[0].
- ROL: Y ← {Y[W−2:0], Y[W−1]}, carry ← Y[W−1].

Outputs:
- `shift_done` = (state == DONE).
- `shift_busy` = (state == SHIFT).
- `y_shifted` is a registered output with no combinational path from any input.

## Timing
- Start sampled at edge 0 with N > 0: shifts occur on edges 1..N, DONE is entered at edge N, and `shift_done` is high for exactly the following cycle.
- With N = 0, `shift_done` is high in the cycle after edge 0.
- `Y_load` latency: `y_shifted` equals `bus` in the cycle after the load edge.
- Back-to-back: a `shift_start` asserted during the DONE cycle is accepted; `shift_done` then pulses only once for the completed shift.
- Mode and amount inputs are don't-care outside the start cycle.

## Structure
- The shared package holds:
  - the `shift_mode` encodings `SH_LSL`, `SH_LSR`, `SH_ASR`, `SH_ROL`;
  - the state encodings.
- Single module. A combinational `shift_step` function or sub-module (mode, Y → next Y, carry) is natural and reusable by the verification model.
- The ALU is instantiated separately by the datapath top level.

## Test plan
- Reset mid-SHIFT: all outputs 0 immediately, without waiting for a clock edge; the next start runs normally.
- Load 16'h8001, start LSL amount 1: `shift_done` 2 cycles after the start edge, `y_shifted` = 16'h0002, `shift_carry` = 1.
- Load 16'h8000, ASR amount 15: `shift_busy` high for 15 cycles, `y_shifted` = 16'hFFFF, `shift_carry` = 0.
- Load 16'h1234, ROL amount 4: `y_shifted` = 16'h2341. Then start with amount 0: `shift_done` next cycle, Y unchanged, `shift_carry` = 0.
- Load 16'hF0F0, LSR amount 8, assert `Y_load` with `bus` = 16'hAAAA after 3 steps: `y_shifted` = 16'hAAAA, no `shift_done`, state IDLE, `shift_carry` = 0 (the bit shifted out on the third step).
- Same cycle `Y_load` (bus = 16'h0F00) and `shift_start` LSL 2: Y = 16'h0F00, no shift, no `shift_done`. A `shift_start` during a DONE cycle is accepted.
